sram_ctrl_64x24: RTL and testbench

- Front-end controller that sits directly upstream of the 64-entry x 24-bit masked dual-port SRAM macro (6-bit lanes, 4-bit write mask, 1-cycle registered read).
- After reset it zero-initialises every entry.
- It presents valid/ready read and write request ports to the client.
- It holds read data stable until the next read, and it forwards same-cycle same-address writes into the read result, so clients never see macro garbage or read-during-write ambiguity.

---
 rtl/sram_ctrl_64x24.sv | 124 ++++++++++++
 tb/tb_sram_ctrl_64x24.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl_64x24.sv
// Front-end for the 64x24 masked dual-port SRAM macro: zero-fills the array after reset,
// then serves valid/ready reads and writes with held read data and same-cycle write forwarding.
module sram_ctrl_64x24 #(
    parameter int SETS  = 64,
    parameter int WIDTH = 24,
    parameter int LANES = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     r_req_valid,
    output logic                     r_req_ready,
    input  logic [$clog2(SETS)-1:0]  r_req_addr,
    output logic                     r_resp_valid,
    output logic [WIDTH-1:0]         r_resp_data,
    input  logic                     w_req_valid,
    output logic                     w_req_ready,
    input  logic [$clog2(SETS)-1:0]  w_req_addr,
    input  logic [WIDTH-1:0]         w_req_data,
    input  logic [LANES-1:0]         w_req_mask,
    output logic                     sram_w_en,
    output logic [$clog2(SETS)-1:0]  sram_w_addr,
    output logic [WIDTH-1:0]         sram_w_data,
    output logic [LANES-1:0]         sram_w_mask,
    output logic                     sram_r_en,
    output logic [$clog2(SETS)-1:0]  sram_r_addr,
    input  logic [WIDTH-1:0]         sram_r_data,
    output logic                     dbg_state
);

    localparam int AW = $clog2(SETS);
    localparam int LW = WIDTH / LANES;
    localparam logic [AW:0] INIT_LAST = (AW + 1)'(SETS - 1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AW:0]       init_cnt_q, init_cnt_d;
    logic              resp_valid_q;
    logic [WIDTH-1:0]  hold_q;
    logic              fwd_hit_q;
    logic [WIDTH-1:0]  fwd_data_q;
    logic [LANES-1:0]  fwd_mask_q;

    logic              r_acc;
    logic              w_acc;
    logic              resp_fire;
    logic [WIDTH-1:0]  resolved;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        r_req_ready = 1'b0;
        w_req_ready = 1'b0;
        sram_w_en   = 1'b0;
        sram_w_addr = w_req_addr;
        sram_w_data = w_req_data;
        sram_w_mask = w_req_mask;
        case (state_q)
            ST_INIT: begin
                sram_w_en   = 1'b1;
                sram_w_addr = init_cnt_q[AW-1:0];
                sram_w_data = '0;
                sram_w_mask = '1;
                init_cnt_d  = init_cnt_q + 1'b1;
                if (init_cnt_q == INIT_LAST) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                r_req_ready = 1'b1;
                w_req_ready = 1'b1;
                sram_w_en   = w_req_valid;
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign r_acc       = r_req_valid & r_req_ready;
    assign w_acc       = w_req_valid & w_req_ready;
    assign sram_r_en   = r_acc;
    assign sram_r_addr = r_req_addr;
    assign dbg_state   = (state_q == ST_READY);

    // Lanes written in the same cycle as the read override the macro's collision output.
    always_comb begin
        resolved = sram_r_data;
        for (int k = 0; k < LANES; k++) begin
            if (fwd_hit_q && fwd_mask_q[k]) begin
                resolved[k*LW +: LW] = fwd_data_q[k*LW +: LW];
            end
        end
    end

    // A response due in the same cycle reset rises is suppressed, so it never reaches the client.
    assign resp_fire    = resp_valid_q & ~reset;
    assign r_resp_valid = resp_fire;
    assign r_resp_data  = resp_fire ? resolved : hold_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            resp_valid_q <= 1'b0;
            hold_q       <= '0;
            fwd_hit_q    <= 1'b0;
            fwd_data_q   <= '0;
            fwd_mask_q   <= '0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            resp_valid_q <= r_acc;
            if (resp_valid_q) begin
                hold_q <= resolved;
            end
            fwd_hit_q  <= r_acc & w_acc & (r_req_addr == w_req_addr);
            fwd_data_q <= w_req_data;
            fwd_mask_q <= w_req_mask;
        end
    end

endmodule

// File: tb/tb_sram_ctrl_64x24.sv
// Directed bench for sram_ctrl_64x24 with a behavioural masked SRAM macro that returns
// garbage in written lanes on a same-address read/write collision.
module tb_sram_ctrl_64x24;

    logic        clock;
    logic        reset;
    logic        r_req_valid;
    logic        r_req_ready;
    logic [5:0]  r_req_addr;
    logic        r_resp_valid;
    logic [23:0] r_resp_data;
    logic        w_req_valid;
    logic        w_req_ready;
    logic [5:0]  w_req_addr;
    logic [23:0] w_req_data;
    logic [3:0]  w_req_mask;
    logic        sram_w_en;
    logic [5:0]  sram_w_addr;
    logic [23:0] sram_w_data;
    logic [3:0]  sram_w_mask;
    logic        sram_r_en;
    logic [5:0]  sram_r_addr;
    logic [23:0] sram_r_data;
    logic        dbg_state;

    int          n_cmp;
    int          n_bad;
    logic [23:0] exp_q[$];
    logic        resp_pending;
    logic [23:0] held;
    logic [23:0] mem [64];

    sram_ctrl_64x24 dut (
        .clock        (clock),
        .reset        (reset),
        .r_req_valid  (r_req_valid),
        .r_req_ready  (r_req_ready),
        .r_req_addr   (r_req_addr),
        .r_resp_valid (r_resp_valid),
        .r_resp_data  (r_resp_data),
        .w_req_valid  (w_req_valid),
        .w_req_ready  (w_req_ready),
        .w_req_addr   (w_req_addr),
        .w_req_data   (w_req_data),
        .w_req_mask   (w_req_mask),
        .sram_w_en    (sram_w_en),
        .sram_w_addr  (sram_w_addr),
        .sram_w_data  (sram_w_data),
        .sram_w_mask  (sram_w_mask),
        .sram_r_en    (sram_r_en),
        .sram_r_addr  (sram_r_addr),
        .sram_r_data  (sram_r_data),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    // macro model: registered read, read-first, written lanes garbled on collision
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 24'hC3C3C3;
        sram_r_data = 24'h5A5A5A;
    end

    always @(posedge clock) begin
        if (sram_r_en) begin
            logic [23:0] rd;
            rd = mem[sram_r_addr];
            if (sram_w_en && sram_w_addr == sram_r_addr) begin
                for (int k = 0; k < 4; k++) begin
                    if (sram_w_mask[k]) rd[k*6 +: 6] = 6'h2A;
                end
            end
            sram_r_data <= rd;
        end else begin
            sram_r_data <= 24'h5A5A5A;
        end
        if (sram_w_en) begin
            for (int k = 0; k < 4; k++) begin
                if (sram_w_mask[k]) mem[sram_w_addr][k*6 +: 6] <= sram_w_data[k*6 +: 6];
            end
        end
    end

    // checking
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // drivers
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        r_req_valid = 1'b0;
        r_req_addr  = 6'd0;
        w_req_valid = 1'b0;
        w_req_addr  = 6'd0;
        w_req_data  = 24'd0;
        w_req_mask  = 4'd0;
    endtask

    // One READY-state cycle: drive, check macro strobes and the response due from the previous cycle.
    task automatic cyc(input logic rv, input logic [5:0] ra, input logic [23:0] rexp,
                       input logic wv, input logic [5:0] wa, input logic [23:0] wd,
                       input logic [3:0] wm);
        logic [23:0] e;
        r_req_valid = rv;
        r_req_addr  = ra;
        w_req_valid = wv;
        w_req_addr  = wa;
        w_req_data  = wd;
        w_req_mask  = wm;
        #1;
        chk("rdy", {31'd0, r_req_ready & w_req_ready}, 32'd1);
        chk("sram_r_en", {31'd0, sram_r_en}, {31'd0, rv});
        chk("sram_w_en", {31'd0, sram_w_en}, {31'd0, wv});
        if (rv) chk("sram_r_addr", {26'd0, sram_r_addr}, {26'd0, ra});
        if (wv) chk("sram_w_pass", {sram_w_addr, sram_w_data[21:0], sram_w_mask},
                    {wa, wd[21:0], wm});
        if (resp_pending) begin
            chk("resp_valid", {31'd0, r_resp_valid}, 32'd1);
            if (exp_q.size() == 0) begin
                chk("resp_queue", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("resp_data", {8'd0, r_resp_data}, {8'd0, e});
                held = e;
            end
        end else begin
            chk("resp_idle", {31'd0, r_resp_valid}, 32'd0);
            chk("hold_data", {8'd0, r_resp_data}, {8'd0, held});
        end
        if (rv) exp_q.push_back(rexp);
        resp_pending = rv;
        tick();
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        resp_pending = 1'b0;
        held         = 24'd0;
        reset        = 1'b1;
        drive_idle();
        tick();
        tick();

        // reset state
        chk("rst_r_ready", {31'd0, r_req_ready}, 32'd0);
        chk("rst_w_ready", {31'd0, w_req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, r_resp_valid}, 32'd0);
        chk("rst_resp_data", {8'd0, r_resp_data}, 32'd0);
        chk("rst_w_en", {31'd0, sram_w_en}, 32'd1);
        chk("rst_r_en", {31'd0, sram_r_en}, 32'd0);

        // init sweep with a read of addr 5 held throughout
        reset       = 1'b0;
        r_req_valid = 1'b1;
        r_req_addr  = 6'd5;
        #1;
        for (int i = 0; i < 64; i++) begin
            chk("init_ready", {30'd0, r_req_ready, w_req_ready}, 32'd0);
            chk("init_r_en", {31'd0, sram_r_en}, 32'd0);
            chk("init_w_en", {31'd0, sram_w_en}, 32'd1);
            chk("init_w_addr", {26'd0, sram_w_addr}, i);
            chk("init_w_dm", {4'd0, sram_w_data, sram_w_mask}, 32'h0000000F);
            tick();
        end
        cyc(1'b1, 6'd5, 24'h000000, 1'b0, 6'd0, 24'd0, 4'd0);

        // masked write then read
        cyc(1'b0, 6'd0, 24'd0, 1'b1, 6'd10, 24'hABCDEF, 4'b0101);
        cyc(1'b1, 6'd10, 24'h03C02F, 1'b0, 6'd0, 24'd0, 4'd0);

        // same-cycle forward, then the macro view, then a different-address write
        cyc(1'b0, 6'd0, 24'd0, 1'b1, 6'd7, 24'h111111, 4'hF);
        cyc(1'b1, 6'd7, 24'h3FFFD1, 1'b1, 6'd7, 24'h3FFFC0, 4'b1110);
        cyc(1'b1, 6'd7, 24'h3FFFD1, 1'b0, 6'd0, 24'd0, 4'd0);
        cyc(1'b1, 6'd10, 24'h03C02F, 1'b1, 6'd11, 24'hFFFFFF, 4'hF);
        cyc(1'b0, 6'd0, 24'd0, 1'b0, 6'd0, 24'd0, 4'd0);

        // back-to-back reads then hold
        cyc(1'b0, 6'd0, 24'd0, 1'b1, 6'd1, 24'h123456, 4'hF);
        cyc(1'b0, 6'd0, 24'd0, 1'b1, 6'd2, 24'h654321, 4'hF);
        cyc(1'b0, 6'd0, 24'd0, 1'b1, 6'd3, 24'hA5A5A5, 4'hF);
        cyc(1'b1, 6'd1, 24'h123456, 1'b0, 6'd0, 24'd0, 4'd0);
        cyc(1'b1, 6'd2, 24'h654321, 1'b0, 6'd0, 24'd0, 4'd0);
        cyc(1'b1, 6'd3, 24'hA5A5A5, 1'b0, 6'd0, 24'd0, 4'd0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 6'd0, 24'd0, 1'b0, 6'd0, 24'd0, 4'd0);

        // reset in the response cycle of an accepted read
        r_req_valid = 1'b1;
        r_req_addr  = 6'd1;
        #1;
        chk("mr_accept", {31'd0, sram_r_en}, 32'd1);
        tick();
        drive_idle();
        reset = 1'b1;
        #1;
        chk("mr_no_valid", {31'd0, r_resp_valid}, 32'd0);
        tick();
        chk("mr_no_valid2", {31'd0, r_resp_valid}, 32'd0);
        chk("mr_data_zero", {8'd0, r_resp_data}, 32'd0);
        chk("mr_ready", {31'd0, r_req_ready}, 32'd0);
        held = 24'd0;

        // reset at init_cnt 30 restarts the sweep
        reset = 1'b0;
        #1;
        for (int i = 0; i <= 30; i++) begin
            chk("mi_w_addr", {26'd0, sram_w_addr}, i);
            if (i < 30) tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // requests held during INIT are ignored until READY
        r_req_valid = 1'b1;
        r_req_addr  = 6'd9;
        w_req_valid = 1'b1;
        w_req_addr  = 6'd9;
        w_req_data  = 24'h00003F;
        w_req_mask  = 4'hF;
        #1;
        for (int i = 0; i < 64; i++) begin
            chk("ig_ready", {30'd0, r_req_ready, w_req_ready}, 32'd0);
            chk("ig_r_en", {31'd0, sram_r_en}, 32'd0);
            chk("ig_w_addr", {26'd0, sram_w_addr}, i);
            chk("ig_w_data", {8'd0, sram_w_data}, 32'd0);
            tick();
        end
        cyc(1'b1, 6'd9, 24'h00003F, 1'b1, 6'd9, 24'h00003F, 4'hF);
        cyc(1'b1, 6'd9, 24'h00003F, 1'b0, 6'd0, 24'd0, 4'd0);
        cyc(1'b0, 6'd0, 24'd0, 1'b0, 6'd0, 24'd0, 4'd0);
        cyc(1'b0, 6'd0, 24'd0, 1'b0, 6'd0, 24'd0, 4'd0);

        chk("exp_q_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
